// File: rtl/background_scroll_mapper.sv
// Pipelined background renderer: beam position plus frame-synchronous scroll -> pixel ROM word,
// lane select -> palette lookup -> registered 4-bit colour with valid and opacity flags.
module background_scroll_mapper #(
    parameter int H_RES           = 640,
    parameter int V_RES           = 480,
    parameter int IDX_W           = 8,
    parameter int PIX_PER_WORD    = 8,
    parameter int ROM_LAT         = 2,
    parameter int PAL_LAT         = 1,
    parameter int ADDR_W          = 16,
    parameter int TRANSPARENT_IDX = 0
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic                          pixel_en,
    input  logic                          frame_start,
    input  logic [9:0]                    scroll_x_in,
    input  logic [9:0]                    scroll_y_in,
    input  logic                          scroll_wr,
    output logic                          scroll_err,
    output logic [ADDR_W-1:0]             rom_addr,
    input  logic [IDX_W*PIX_PER_WORD-1:0] rom_data,
    output logic [IDX_W-1:0]              pal_addr,
    input  logic [23:0]                   pal_data,
    output logic [3:0]                    VGA_R,
    output logic [3:0]                    VGA_G,
    output logic [3:0]                    VGA_B,
    output logic                          pix_valid,
    output logic                          bg_opaque
);

    localparam int SHIFT  = $clog2(PIX_PER_WORD);
    localparam int LANE_W = (SHIFT > 0) ? SHIFT : 1;
    localparam int SUM_W  = 12;
    localparam int MUL_W  = 24;
    localparam logic [SUM_W-1:0] H_LIM = SUM_W'(H_RES);
    localparam logic [SUM_W-1:0] V_LIM = SUM_W'(V_RES);

    logic [9:0]        r_pend_x, r_pend_y;
    logic [9:0]        r_act_x, r_act_y;
    logic              r_a_active;
    logic [LANE_W-1:0] r_a_lane;
    logic              r_rd_active [ROM_LAT];
    logic [LANE_W-1:0] r_rd_lane   [ROM_LAT];
    logic              r_b_active;
    logic              r_b_opaque;
    logic              r_pd_active [PAL_LAT];
    logic              r_pd_opaque [PAL_LAT];

    logic              w_wr_ok;
    logic              w_active;
    logic [SUM_W-1:0]  w_sum_x, w_sum_y, w_sx, w_sy;
    logic [MUL_W-1:0]  w_lin, w_word;
    logic [LANE_W-1:0] w_lane;
    logic [IDX_W-1:0]  w_idx;
    logic              w_rd_active;
    logic [LANE_W-1:0] w_rd_lane;
    logic              w_unused_pal;

    assign w_wr_ok  = scroll_wr && ({2'b00, scroll_x_in} < H_LIM) && ({2'b00, scroll_y_in} < V_LIM);
    assign w_active = pixel_en && ({2'b00, DrawX} < H_LIM) && ({2'b00, DrawY} < V_LIM);

    // Single conditional subtract is enough: both operands are below the limit when active.
    assign w_sum_x = {2'b00, DrawX} + {2'b00, r_act_x};
    assign w_sum_y = {2'b00, DrawY} + {2'b00, r_act_y};
    assign w_sx    = (w_sum_x >= H_LIM) ? w_sum_x - H_LIM : w_sum_x;
    assign w_sy    = (w_sum_y >= V_LIM) ? w_sum_y - V_LIM : w_sum_y;
    assign w_lin   = MUL_W'(w_sy) * MUL_W'(H_RES) + MUL_W'(w_sx);
    assign w_word  = w_lin >> SHIFT;
    assign w_lane  = (SHIFT > 0) ? w_sx[LANE_W-1:0] : '0;

    assign w_rd_active  = r_rd_active[ROM_LAT-1];
    assign w_rd_lane    = r_rd_lane[ROM_LAT-1];
    assign w_unused_pal = ^{pal_data[19:16], pal_data[11:8], pal_data[3:0]};

    // Lane 0 sits in the most significant bits of the ROM word.
    always_comb begin
        w_idx = '0;
        for (int n = 0; n < PIX_PER_WORD; n++) begin
            if (w_rd_lane == LANE_W'(n)) begin
                w_idx = rom_data[(PIX_PER_WORD-n)*IDX_W-1 -: IDX_W];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pend_x   <= '0;
            r_pend_y   <= '0;
            r_act_x    <= '0;
            r_act_y    <= '0;
            scroll_err <= 1'b0;
        end else begin
            scroll_err <= scroll_wr && !w_wr_ok;
            if (w_wr_ok) begin
                r_pend_x <= scroll_x_in;
                r_pend_y <= scroll_y_in;
            end
            if (frame_start) begin
                r_act_x <= w_wr_ok ? scroll_x_in : r_pend_x;
                r_act_y <= w_wr_ok ? scroll_y_in : r_pend_y;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr   <= '0;
            r_a_lane   <= '0;
            r_a_active <= 1'b0;
            for (int i = 0; i < ROM_LAT; i++) begin
                r_rd_active[i] <= 1'b0;
                r_rd_lane[i]   <= '0;
            end
        end else begin
            r_a_active <= w_active;
            if (w_active) begin
                rom_addr <= ADDR_W'(w_word);
                r_a_lane <= w_lane;
            end
            r_rd_active[0] <= r_a_active;
            r_rd_lane[0]   <= r_a_lane;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_rd_active[i] <= r_rd_active[i-1];
                r_rd_lane[i]   <= r_rd_lane[i-1];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pal_addr   <= '0;
            r_b_active <= 1'b0;
            r_b_opaque <= 1'b0;
            for (int i = 0; i < PAL_LAT; i++) begin
                r_pd_active[i] <= 1'b0;
                r_pd_opaque[i] <= 1'b0;
            end
        end else begin
            r_b_active <= w_rd_active;
            if (w_rd_active) begin
                pal_addr   <= w_idx;
                r_b_opaque <= (w_idx != IDX_W'(TRANSPARENT_IDX));
            end
            r_pd_active[0] <= r_b_active;
            r_pd_opaque[0] <= r_b_opaque;
            for (int i = 1; i < PAL_LAT; i++) begin
                r_pd_active[i] <= r_pd_active[i-1];
                r_pd_opaque[i] <= r_pd_opaque[i-1];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
            pix_valid <= 1'b0;
            bg_opaque <= 1'b0;
        end else if (r_pd_active[PAL_LAT-1]) begin
            VGA_R     <= pal_data[23:20];
            VGA_G     <= pal_data[15:12];
            VGA_B     <= pal_data[7:4];
            pix_valid <= 1'b1;
            bg_opaque <= r_pd_opaque[PAL_LAT-1];
        end else begin
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
            pix_valid <= 1'b0;
            bg_opaque <= 1'b0;
        end
    end

endmodule

// File: tb/tb_background_scroll_mapper.sv
// Scoreboard bench for background_scroll_mapper: behavioural ROM/palette models, scroll model,
// expected colour queued at issue and compared L edges later.
module tb_background_scroll_mapper;

    localparam int L = 6;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic        pixel_en = 1'b0, frame_start = 1'b0, scroll_wr = 1'b0;
    logic [9:0]  scroll_x_in = '0, scroll_y_in = '0;
    logic        scroll_err;
    logic [15:0] rom_addr;
    logic [63:0] rom_data;
    logic [7:0]  pal_addr;
    logic [23:0] pal_data;
    logic [3:0]  VGA_R, VGA_G, VGA_B;
    logic        pix_valid, bg_opaque;

    background_scroll_mapper dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .pixel_en(pixel_en), .frame_start(frame_start),
        .scroll_x_in(scroll_x_in), .scroll_y_in(scroll_y_in), .scroll_wr(scroll_wr),
        .scroll_err(scroll_err), .rom_addr(rom_addr), .rom_data(rom_data),
        .pal_addr(pal_addr), .pal_data(pal_data),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .pix_valid(pix_valid), .bg_opaque(bg_opaque)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Pixel p = y*640 + x holds index (p*37 + 221) mod 256: p=9 -> 0x2A, p=167 -> 0.
    function automatic logic [7:0] idx_fn(input int p);
        return 8'(p * 37 + 221);
    endfunction

    function automatic logic [23:0] pal_fn(input logic [7:0] i);
        if (i == 8'h2A) return 24'hF0A050;
        return {i, i ^ 8'hFF, i ^ 8'h5A};
    endfunction

    function automatic logic [63:0] rom_word(input logic [15:0] a);
        logic [63:0] w;
        w = '0;
        for (int l = 0; l < 8; l++) w[(8-l)*8-1 -: 8] = idx_fn(int'(a) * 8 + l);
        return w;
    endfunction

    logic [15:0] addr_q [2];
    logic [7:0]  pal_q;
    always @(posedge Clk) begin
        addr_q[0] <= rom_addr;
        addr_q[1] <= addr_q[0];
        pal_q     <= pal_addr;
    end
    assign rom_data = rom_word(addr_q[1]);
    assign pal_data = pal_fn(pal_q);

    typedef struct {
        int         due;
        logic [13:0] exp;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;
    logic [13:0] mon_got;

    always @(negedge Clk) begin
        if (Reset_n) begin
            while (q.size() > 0 && q[0].due <= cyc) begin
                mon_e   = q.pop_front();
                mon_got = {pix_valid, VGA_R, VGA_G, VGA_B, bg_opaque};
                n_checks++;
                if (mon_got !== mon_e.exp) begin
                    n_errors++;
                    $display("FAIL pixel_out due=%0d got {v,R,G,B,op}=%h expected %h",
                             mon_e.due, mon_got, mon_e.exp);
                end
            end
        end
    end

    int m_ax = 0, m_ay = 0, m_px = 0, m_py = 0, m_addr = 0;

    task automatic model_reset();
        m_ax = 0; m_ay = 0; m_px = 0; m_py = 0; m_addr = 0;
    endtask

    task automatic drive_cycle(input int x, input int y, input bit en, input bit fs,
                               input bit wr, input int wx, input int wy);
        bit act, ok;
        int sx, sy, p;
        logic [7:0] idx;
        logic [23:0] pd;
        exp_t e;
        @(negedge Clk);
        DrawX = 10'(x); DrawY = 10'(y); pixel_en = en;
        frame_start = fs; scroll_wr = wr;
        scroll_x_in = 10'(wx); scroll_y_in = 10'(wy);
        act = en && x < 640 && y < 480;
        sx = x + m_ax; if (sx >= 640) sx -= 640;
        sy = y + m_ay; if (sy >= 480) sy -= 480;
        p   = sy * 640 + sx;
        idx = idx_fn(p);
        pd  = pal_fn(idx);
        e.due = cyc + L;
        e.exp = act ? {1'b1, pd[23:20], pd[15:12], pd[7:4], idx != 8'h00} : 14'h0;
        q.push_back(e);
        if (act) m_addr = p / 8;
        ok = wr && wx < 640 && wy < 480;
        if (fs) begin
            m_ax = ok ? wx : m_px;
            m_ay = ok ? wy : m_py;
        end
        if (ok) begin
            m_px = wx; m_py = wy;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        n_checks++;
        if ({rom_addr, pal_addr, VGA_R, VGA_G, VGA_B, pix_valid, bg_opaque, scroll_err} !== 39'h0) begin
            n_errors++;
            $display("FAIL reset_state got addr=%h pal=%h rgb=%h%h%h v=%b op=%b err=%b required all 0",
                     rom_addr, pal_addr, VGA_R, VGA_G, VGA_B, pix_valid, bg_opaque, scroll_err);
        end
        Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        drive_cycle(9, 0, 1, 0, 0, 0, 0);
        n_checks++;
        if (rom_addr !== 16'd1) begin
            n_errors++; $display("FAIL basic_rom_addr got %0d required 1", rom_addr);
        end
        idle(3);
        n_checks++;
        if (pal_addr !== 8'h2A) begin
            n_errors++; $display("FAIL basic_pal_addr got %h required 2a", pal_addr);
        end
        idle(3);
    endtask

    task automatic test_scroll_deferred();
        drive_cycle(0, 0, 0, 0, 1, 635, 0);
        drive_cycle(10, 0, 1, 0, 0, 0, 0);
        n_checks++;
        if (rom_addr !== 16'd1) begin
            n_errors++; $display("FAIL scroll_before_commit got %0d required 1", rom_addr);
        end
        drive_cycle(0, 0, 0, 1, 0, 0, 0);
        drive_cycle(10, 0, 1, 0, 0, 0, 0);
        n_checks++;
        if (rom_addr !== 16'd0) begin
            n_errors++; $display("FAIL scroll_after_commit got %0d required 0", rom_addr);
        end
        idle(2);
    endtask

    task automatic test_scroll_y();
        drive_cycle(0, 0, 0, 0, 1, 0, 479);
        drive_cycle(0, 0, 0, 1, 0, 0, 0);
        drive_cycle(0, 2, 1, 0, 0, 0, 0);
        n_checks++;
        if (rom_addr !== 16'd80) begin
            n_errors++; $display("FAIL scroll_y_wrap got %0d required 80", rom_addr);
        end
        idle(2);
    endtask

    task automatic test_scroll_err();
        drive_cycle(0, 0, 0, 0, 1, 640, 0);
        n_checks++;
        if (scroll_err !== 1'b1) begin
            n_errors++; $display("FAIL scroll_err_x_pulse got %b required 1", scroll_err);
        end
        drive_cycle(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (scroll_err !== 1'b0) begin
            n_errors++; $display("FAIL scroll_err_one_cycle got %b required 0", scroll_err);
        end
        drive_cycle(0, 0, 0, 0, 1, 5, 480);
        n_checks++;
        if (scroll_err !== 1'b1) begin
            n_errors++; $display("FAIL scroll_err_y_pulse got %b required 1", scroll_err);
        end
        drive_cycle(0, 0, 0, 1, 0, 0, 0);
        drive_cycle(0, 2, 1, 0, 0, 0, 0);
        n_checks++;
        if (rom_addr !== 16'd80) begin
            n_errors++; $display("FAIL scroll_err_unchanged got %0d required 80", rom_addr);
        end
        drive_cycle(0, 0, 0, 1, 1, 3, 0);
        n_checks++;
        if (scroll_err !== 1'b0) begin
            n_errors++; $display("FAIL scroll_err_spurious got %b required 0", scroll_err);
        end
        drive_cycle(0, 0, 1, 0, 0, 0, 0);
        n_checks++;
        if (rom_addr !== 16'd0) begin
            n_errors++; $display("FAIL same_edge_commit got %0d required 0", rom_addr);
        end
        idle(2);
    endtask

    task automatic test_inactive_opacity();
        int prev;
        drive_cycle(6, 0, 1, 0, 0, 0, 0);
        prev = m_addr;
        drive_cycle(640, 0, 1, 0, 0, 0, 0);
        n_checks++;
        if (rom_addr !== 16'(prev)) begin
            n_errors++; $display("FAIL hold_x_oob got %0d required %0d", rom_addr, prev);
        end
        drive_cycle(5, 5, 0, 0, 0, 0, 0);
        n_checks++;
        if (rom_addr !== 16'(prev)) begin
            n_errors++; $display("FAIL hold_no_en got %0d required %0d", rom_addr, prev);
        end
        drive_cycle(0, 480, 1, 0, 0, 0, 0);
        drive_cycle(164, 0, 1, 0, 0, 0, 0);
        drive_cycle(6, 0, 1, 0, 0, 0, 0);
        idle(2);
    endtask

    task automatic test_back_to_back();
        int x, y, wx, wy;
        bit en, fs, wr, exp_err;
        for (int i = 0; i < 60; i++) begin
            x  = $urandom_range(0, 700);
            y  = $urandom_range(0, 520);
            en = ($urandom_range(0, 3) != 0);
            fs = ($urandom_range(0, 7) == 0);
            wr = ($urandom_range(0, 5) == 0);
            wx = $urandom_range(0, 700);
            wy = $urandom_range(0, 520);
            exp_err = wr && !(wx < 640 && wy < 480);
            drive_cycle(x, y, en, fs, wr, wx, wy);
            n_checks++;
            if (rom_addr !== 16'(m_addr) || scroll_err !== exp_err) begin
                n_errors++;
                $display("FAIL b2b_addr_err i=%0d got addr=%0d err=%b required addr=%0d err=%b",
                         i, rom_addr, scroll_err, m_addr, exp_err);
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 8; i++) drive_cycle(20 + i, 7, 1, 0, 0, 0, 0);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        q.delete();
        model_reset();
        n_checks++;
        if ({rom_addr, pal_addr, VGA_R, VGA_G, VGA_B, pix_valid, bg_opaque, scroll_err} !== 39'h0) begin
            n_errors++;
            $display("FAIL midstream_reset got addr=%h pal=%h rgb=%h%h%h v=%b op=%b required all 0",
                     rom_addr, pal_addr, VGA_R, VGA_G, VGA_B, pix_valid, bg_opaque);
        end
        repeat (3) @(posedge Clk);
        #2;
        Reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            drive_cycle(k * 3, 1, 1, 0, 0, 0, 0);
            n_checks++;
            if (pix_valid !== (k >= L)) begin
                n_errors++;
                $display("FAIL post_reset_valid edge=%0d got %b required %b", k, pix_valid, (k >= L));
            end
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_scroll_deferred();
        test_scroll_y();
        test_scroll_err();
        test_inactive_opacity();
        test_back_to_back();
        test_reset_midstream();
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge Clk);
        #1;
        if (q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout got %0d pending required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
